// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU vector sequencer.
//   - Default widths for the sequencer and its bus interface.
//   - ALU opcode encodings. Any opcode above OP_D_RELU is illegal.
//   - The sequencer FSM state type.
//   - The latched command record.
package vpu_pkg;

    localparam int VPU_DATA_W = 32;
    localparam int VPU_OP_W   = 10;
    localparam int VPU_ADDR_W = 10;
    localparam int VPU_LEN_W  = 11;

    localparam logic [VPU_OP_W-1:0] OP_ADD    = VPU_OP_W'(0);
    localparam logic [VPU_OP_W-1:0] OP_SUB    = VPU_OP_W'(1);
    localparam logic [VPU_OP_W-1:0] OP_RELU   = VPU_OP_W'(2);
    localparam logic [VPU_OP_W-1:0] OP_MUL    = VPU_OP_W'(3);
    localparam logic [VPU_OP_W-1:0] OP_D_RELU = VPU_OP_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [VPU_OP_W-1:0]   opcode;
        logic [VPU_ADDR_W-1:0] src0;
        logic [VPU_ADDR_W-1:0] src1;
        logic [VPU_ADDR_W-1:0] dst;
        logic [VPU_LEN_W-1:0]  len;
    } cmd_t;

endpackage

// File: rtl/vpu_vec_seq_if.sv
// Bus bundle of the vector sequencer. It carries the command channel, the
// scratchpad read and write ports, the ALU operand and result wires, and
// the status signals.
//   slave  : the sequencer's view. It takes commands, read data and ALU
//            results, and drives everything else.
//   master : the surrounding logic's view, which is the mirror image.
interface vpu_vec_seq_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 10,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode;
    logic [ADDR_W-1:0] cmd_src0;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_operand0;
    logic [DATA_W-1:0] alu_operand1;
    logic [DATA_W-1:0] alu_result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_src0, cmd_src1, cmd_dst, cmd_len,
        input  rd_data0, rd_data1, alu_result,
        output cmd_ready, rd_en, rd_addr0, rd_addr1,
        output alu_opcode, alu_operand0, alu_operand1,
        output wr_en, wr_addr, wr_data, busy, done, err
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_src0, cmd_src1, cmd_dst, cmd_len,
        output rd_data0, rd_data1, alu_result,
        input  cmd_ready, rd_en, rd_addr0, rd_addr1,
        input  alu_opcode, alu_operand0, alu_operand1,
        input  wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/vpu_addr_gen.sv
// Wrapping address generator for one stream.
//   en     : stream active; when low, the address output is forced to 0
//   base   : stream base address
//   offset : element index (low ADDR_W bits)
//   addr   : base + offset modulo 2^ADDR_W
module vpu_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] addr
);
    // The sum is truncated to ADDR_W bits, so it wraps silently at the top
    // of the scratchpad.
    assign addr = en ? (base + offset) : '0;
endmodule

// File: rtl/vpu_vec_seq.sv
// Elementwise vector sequencer in front of the combinational VPU ALU.
// It accepts one command, then reads operand pairs at one element per
// cycle. The read data is driven straight into the ALU operands, and the
// ALU result is registered. Each result is written back two cycles after
// its read. At the end, done is pulsed for one cycle, and err is set along
// with done when the opcode was illegal.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : vpu_vec_seq_if.slave, which holds the command, scratchpad,
//                ALU and status signals
module vpu_vec_seq
    import vpu_pkg::*;
#(
    parameter int DATA_W = VPU_DATA_W,
    parameter int OP_W   = VPU_OP_W,
    parameter int ADDR_W = VPU_ADDR_W,
    parameter int LEN_W  = VPU_LEN_W
) (
    input  logic          clk,
    input  logic          rst_n,
    vpu_vec_seq_if.slave  bus
);
    state_t            state_reg, state_next;
    cmd_t              cmd_reg;
    logic [LEN_W-1:0]  issue_cnt_reg;
    logic [ADDR_W-1:0] wr_cnt_reg;
    logic              rd_vld_reg;    // read data is present on rd_data0/1 this cycle
    logic              wr_vld_reg;    // wr_data_reg holds a result to write this cycle
    logic [DATA_W-1:0] wr_data_reg;

    logic accept, issuing, last_issue, bad_cmd;

    assign accept     = (state_reg == ST_IDLE) && bus.cmd_valid;
    assign issuing    = (state_reg == ST_ISSUE);
    assign last_issue = (issue_cnt_reg == (cmd_reg.len - LEN_W'(1)));
    // Illegal and empty commands skip the datapath and go straight to FIN.
    assign bad_cmd    = (bus.cmd_opcode > OP_D_RELU) || (bus.cmd_len == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= '0;
            issue_cnt_reg <= '0;
            wr_cnt_reg    <= '0;
            rd_vld_reg    <= 1'b0;
            wr_vld_reg    <= 1'b0;
            wr_data_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cmd_reg       <= '{opcode: bus.cmd_opcode, src0: bus.cmd_src0,
                                   src1: bus.cmd_src1, dst: bus.cmd_dst,
                                   len: bus.cmd_len};
                issue_cnt_reg <= '0;
                wr_cnt_reg    <= '0;
            end else begin
                if (issuing)    issue_cnt_reg <= issue_cnt_reg + LEN_W'(1);
                if (wr_vld_reg) wr_cnt_reg    <= wr_cnt_reg + ADDR_W'(1);
            end
            rd_vld_reg  <= issuing;
            wr_vld_reg  <= rd_vld_reg;
            wr_data_reg <= rd_vld_reg ? bus.alu_result : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (accept) state_next = bad_cmd ? ST_FIN : ST_ISSUE;
            ST_ISSUE: if (last_issue) state_next = ST_DRAIN;
            // Once the last read's data has gone through the ALU, its result
            // sits in wr_data_reg and is written this cycle.
            ST_DRAIN: if (!rd_vld_reg) state_next = ST_FIN;
            ST_FIN:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // There are three address streams: src0, src1 and dst. Each adds its
    // own base to an element counter.
    logic [ADDR_W-1:0] gen_base [3];
    logic [ADDR_W-1:0] gen_off  [3];
    logic              gen_en   [3];
    logic [ADDR_W-1:0] gen_addr [3];

    assign gen_base[0] = cmd_reg.src0;
    assign gen_base[1] = cmd_reg.src1;
    assign gen_base[2] = cmd_reg.dst;
    assign gen_off[0]  = issue_cnt_reg[ADDR_W-1:0];
    assign gen_off[1]  = issue_cnt_reg[ADDR_W-1:0];
    assign gen_off[2]  = wr_cnt_reg;
    assign gen_en[0]   = issuing;
    assign gen_en[1]   = issuing;
    assign gen_en[2]   = wr_vld_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_addr
            vpu_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
                .en     (gen_en[gi]),
                .base   (gen_base[gi]),
                .offset (gen_off[gi]),
                .addr   (gen_addr[gi])
            );
        end
    endgenerate

    assign bus.cmd_ready    = (state_reg == ST_IDLE);
    assign bus.busy         = (state_reg != ST_IDLE);
    assign bus.rd_en        = issuing;
    assign bus.rd_addr0     = gen_addr[0];
    assign bus.rd_addr1     = gen_addr[1];
    assign bus.alu_opcode   = bus.busy ? cmd_reg.opcode : '0;
    assign bus.alu_operand0 = rd_vld_reg ? bus.rd_data0 : '0;
    assign bus.alu_operand1 = rd_vld_reg ? bus.rd_data1 : '0;
    assign bus.wr_en        = wr_vld_reg;
    assign bus.wr_addr      = gen_addr[2];
    assign bus.wr_data      = wr_data_reg;
    assign bus.done         = (state_reg == ST_FIN);
    assign bus.err          = (state_reg == ST_FIN) && (cmd_reg.opcode > OP_D_RELU);

endmodule

// File: tb/tb_vpu_vec_seq.sv
// Directed testbench for vpu_vec_seq. It contains a scratchpad model with
// registered reads and a small FP32 ALU model. A negedge monitor logs every
// read, write and done pulse, stamped with the cycle number. Each test task
// checks these logs against hand-computed expectations.
module tb_vpu_vec_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vpu_vec_seq_if #(.DATA_W(32), .OP_W(10), .ADDR_W(10), .LEN_W(11)) bus ();

    vpu_vec_seq #(.DATA_W(32), .OP_W(10), .ADDR_W(10), .LEN_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int          wr_c[$];
    logic [9:0]  wr_a[$];
    logic [31:0] wr_d[$];
    int          rd_c[$];
    logic [9:0]  rd_a0[$];
    logic [9:0]  rd_a1[$];
    int          done_c[$];
    logic        done_e[$];

    // FP32 <-> real conversions. They cover normal numbers and zero, which
    // is enough for the test values used here.
    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'h0;
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] alu_model(logic [9:0] op, logic [31:0] x, logic [31:0] y);
        real a, b;
        a = f2r(x);
        b = f2r(y);
        case (op)
            10'd0:   return r2f(a + b);
            10'd1:   return r2f(a - b);
            10'd2:   return (a > 0.0) ? x : 32'h0;
            10'd3:   return r2f(a * b);
            10'd4:   return (a > 0.0) ? 32'h3F800000 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    always_comb bus.alu_result = alu_model(bus.alu_opcode, bus.alu_operand0, bus.alu_operand1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rd_en) begin
            bus.rd_data0 <= mem[bus.rd_addr0];
            bus.rd_data1 <= mem[bus.rd_addr1];
        end
    end

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_c.push_back(cyc); wr_a.push_back(bus.wr_addr); wr_d.push_back(bus.wr_data);
        end
        if (bus.rd_en) begin
            rd_c.push_back(cyc); rd_a0.push_back(bus.rd_addr0); rd_a1.push_back(bus.rd_addr1);
        end
        if (bus.done) begin
            done_c.push_back(cyc); done_e.push_back(bus.err);
        end
    end

    task automatic clear_logs();
        wr_c.delete(); wr_a.delete(); wr_d.delete();
        rd_c.delete(); rd_a0.delete(); rd_a1.delete();
        done_c.delete(); done_e.delete();
    endtask

    // Offers a command for exactly one cycle while the sequencer is idle.
    // t is the acceptance cycle T.
    task automatic run_cmd(input logic [9:0] op, input logic [9:0] s0, input logic [9:0] s1,
                           input logic [9:0] d, input logic [10:0] len, output int t);
        @(negedge clk);
        bus.cmd_opcode = op; bus.cmd_src0 = s0; bus.cmd_src1 = s1;
        bus.cmd_dst = d; bus.cmd_len = len; bus.cmd_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        for (int k = 0; k < budget; k++) begin
            if (done_c.size() != 0) break;
            @(negedge clk); #1;
        end
        seen = (done_c.size() != 0);
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_src0 = '0;
        bus.cmd_src1 = '0; bus.cmd_dst = '0; bus.cmd_len = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.err, bus.rd_addr0, bus.rd_addr1,
             bus.wr_addr, bus.wr_data, bus.alu_operand0, bus.alu_operand1, bus.alu_opcode} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd_en=%0b wr_en=%0b busy=%0b done=%0b wr_data=%h want all 0",
                     bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%0b busy=%0b want 1/0", bus.cmd_ready, bus.busy);
        end
        $display("reset: released at cycle %0d", cyc);
    endtask

    task automatic test_add();
        int t;
        bit seen;
        logic [31:0] exp_d [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        mem[0] = 32'h3F800000; mem[1] = 32'h40000000; mem[2] = 32'h40400000; mem[3] = 32'h40800000;
        for (int i = 0; i < 4; i++) mem[16+i] = 32'h3F800000;
        clear_logs();
        run_cmd(10'd0, 10'd0, 10'd16, 10'd32, 11'd4, t);
        // Hold a second command on the bus while busy; it must be ignored.
        bus.cmd_len = 11'd0; bus.cmd_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.rd_en !== 1'b1 ||
            bus.rd_addr0 !== 10'd0 || bus.rd_addr1 !== 10'd16) begin
            n_fail++;
            $display("FAIL add_first_issue: busy=%0b ready=%0b rd_en=%0b a0=%0d a1=%0d want 1/0/1/0/16",
                     bus.busy, bus.cmd_ready, bus.rd_en, bus.rd_addr0, bus.rd_addr1);
        end
        wait_done(20, seen);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (!seen || done_c.size() != 1 || done_c[0] != t + 7 || done_e[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: seen=%0b count=%0d cycle=%0d want count 1 at %0d err 0",
                     seen, done_c.size(), seen ? done_c[0] : -1, t + 7);
        end
        n_checks++;
        if (rd_c.size() != 4 || rd_c[0] != t + 1 || rd_a0[3] !== 10'd3 || rd_a1[3] !== 10'd19) begin
            n_fail++;
            $display("FAIL add_reads: count=%0d want 4 starting at %0d", rd_c.size(), t + 1);
        end
        n_checks++;
        if (wr_c.size() != 4) begin
            n_fail++;
            $display("FAIL add_wr_count: got %0d want 4", wr_c.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= wr_c.size() || wr_c[i] != t + 3 + i || wr_a[i] !== 10'(32 + i) || wr_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL add_wr%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                         i, (i < wr_c.size()) ? wr_c[i] : -1, (i < wr_c.size()) ? wr_a[i] : 10'd0,
                         (i < wr_c.size()) ? wr_d[i] : 32'h0, t + 3 + i, 32 + i, exp_d[i]);
            end
        end
        $display("add: T=%0d writes=%0d done_count=%0d", t, wr_c.size(), done_c.size());
    endtask

    task automatic test_relu();
        int t;
        bit seen;
        logic [31:0] exp_d [3] = '{32'h0, 32'h0, 32'h40A00000};
        mem[40] = 32'hC0000000; mem[41] = 32'h00000000; mem[42] = 32'h40A00000;
        clear_logs();
        run_cmd(10'd2, 10'd40, 10'd50, 10'd60, 11'd3, t);
        wait_done(20, seen);
        n_checks++;
        if (!seen || done_c[0] != t + 6 || done_e[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL relu_done: seen=%0b cycle=%0d want %0d err 0", seen, seen ? done_c[0] : -1, t + 6);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= wr_c.size() || wr_c[i] != t + 3 + i || wr_a[i] !== 10'(60 + i) || wr_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL relu_wr%0d: got data=%h addr=%0d want data=%h addr=%0d", i,
                         (i < wr_c.size()) ? wr_d[i] : 32'h0, (i < wr_c.size()) ? wr_a[i] : 10'd0,
                         exp_d[i], 60 + i);
            end
        end
        $display("relu: T=%0d writes=%0d", t, wr_c.size());
    endtask

    // Commands that bypass the datapath: done at T+1 and no memory traffic.
    task automatic test_bypass(input logic [9:0] op, input logic [10:0] len, input logic exp_err);
        int t;
        bit seen;
        clear_logs();
        run_cmd(op, 10'd0, 10'd16, 10'd32, len, t);
        wait_done(10, seen);
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (!seen || done_c[0] != t + 1 || done_e[0] !== exp_err) begin
            n_fail++;
            $display("FAIL bypass_op%0d_len%0d_done: seen=%0b cycle=%0d err=%0b want %0d err %0b",
                     op, len, seen, seen ? done_c[0] : -1, seen ? done_e[0] : 1'b0, t + 1, exp_err);
        end
        n_checks++;
        if (rd_c.size() != 0 || wr_c.size() != 0) begin
            n_fail++;
            $display("FAIL bypass_op%0d_len%0d_traffic: reads=%0d writes=%0d want 0/0",
                     op, len, rd_c.size(), wr_c.size());
        end
        $display("bypass: op=%0d len=%0d T=%0d done_count=%0d", op, len, t, done_c.size());
    endtask

    task automatic test_wrap();
        int t;
        bit seen;
        logic [9:0]  exp_r [3] = '{10'd1022, 10'd1023, 10'd0};
        logic [9:0]  exp_w [3] = '{10'd1023, 10'd0, 10'd1};
        logic [31:0] exp_d [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        mem[1022] = 32'h3F800000; mem[1023] = 32'h40000000; mem[0] = 32'h40400000;
        mem[100] = 32'h0; mem[101] = 32'h0; mem[102] = 32'h0;
        clear_logs();
        run_cmd(10'd0, 10'd1022, 10'd100, 10'd1023, 11'd3, t);
        wait_done(20, seen);
        n_checks++;
        if (!seen || done_c[0] != t + 6) begin
            n_fail++;
            $display("FAIL wrap_done: seen=%0b cycle=%0d want %0d", seen, seen ? done_c[0] : -1, t + 6);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= rd_c.size() || i >= wr_c.size() || rd_a0[i] !== exp_r[i] ||
                wr_a[i] !== exp_w[i] || wr_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL wrap_elem%0d: rd=%0d wr=%0d data=%h want rd=%0d wr=%0d data=%h", i,
                         (i < rd_c.size()) ? rd_a0[i] : 10'd0, (i < wr_c.size()) ? wr_a[i] : 10'd0,
                         (i < wr_c.size()) ? wr_d[i] : 32'h0, exp_r[i], exp_w[i], exp_d[i]);
            end
        end
        $display("wrap: T=%0d reads=%0d writes=%0d", t, rd_c.size(), wr_c.size());
    endtask

    task automatic test_reset_mid();
        int t, t2;
        bit seen;
        for (int i = 0; i < 8; i++) begin
            mem[200+i] = 32'h40000000;
            mem[210+i] = 32'h3F800000;
        end
        clear_logs();
        run_cmd(10'd3, 10'd200, 10'd210, 10'd220, 11'd8, t);
        repeat (3) @(negedge clk);   // negedge of cycle T+4
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.err, bus.rd_addr0, bus.rd_addr1,
             bus.wr_addr, bus.wr_data, bus.alu_operand0, bus.alu_operand1, bus.alu_opcode} !== '0 ||
            bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: rd_en=%0b wr_en=%0b busy=%0b wr_data=%h opcode=%0d want 0",
                     bus.rd_en, bus.wr_en, bus.busy, bus.wr_data, bus.alu_opcode);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (done_c.size() != 0 || wr_c.size() != 2 || wr_a[0] !== 10'd220 || wr_a[1] !== 10'd221 ||
            wr_d[1] !== 32'h40000000) begin
            n_fail++;
            $display("FAIL midreset_aborted: dones=%0d writes=%0d want 0 dones and 2 writes to 220,221",
                     done_c.size(), wr_c.size());
        end
        mem[230] = 32'h40000000; mem[231] = 32'h40400000;
        clear_logs();
        run_cmd(10'd3, 10'd230, 10'd231, 10'd240, 11'd1, t2);
        wait_done(10, seen);
        n_checks++;
        if (!seen || done_c[0] != t2 + 4 || done_e[0] !== 1'b0 || wr_c.size() != 1 ||
            wr_c[0] != t2 + 3 || wr_a[0] !== 10'd240 || wr_d[0] !== 32'h40C00000) begin
            n_fail++;
            $display("FAIL midreset_restart: seen=%0b done=%0d writes=%0d data=%h want done %0d, 1 write 40c00000 @240",
                     seen, seen ? done_c[0] : -1, wr_c.size(), (wr_c.size() != 0) ? wr_d[0] : 32'h0, t2 + 4);
        end
        $display("reset_mid: T=%0d restart T'=%0d done_count=%0d", t, t2, done_c.size());
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_add();
        test_relu();
        test_bypass(10'd7, 11'd8, 1'b1);
        test_bypass(10'd0, 11'd0, 1'b0);
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
